// File: rtl/sse_sample_feeder_if.sv
// Sample handshake between the feeder (master) and the SSE engine (slave).
// The feeder drives the sample pair, end-of-stream and the engine reset.
// The engine returns its pair request, result-valid and accumulated result.
interface sse_sample_feeder_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        stop;
  logic        sse_rst;
  logic        next;
  logic        ready;
  logic [31:0] Y;

  modport master (
    output A, B, stop, sse_rst,
    input  next, ready, Y
  );

  modport slave (
    input  A, B, stop, sse_rst,
    output next, ready, Y
  );
endinterface

// File: rtl/sse_sample_feeder.sv
// sse_sample_feeder: holds reference/measured sample buffers, streams them as
// A/B pairs to the SSE engine one pair per `next` edge, raises `stop` after
// the last pair and captures Y on the engine's `ready` edge.
// Optional macro SSE_FEEDER_TIMEOUT_EN adds an `error` output and a watchdog
// that aborts a run after TIMEOUT cycles without engine progress.
module sse_sample_feeder #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [AW-1:0]         wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [AW:0]           count,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           result,
`ifdef SSE_FEEDER_TIMEOUT_EN
  output logic                  error,
`endif
  sse_sample_feeder_if.master   eng
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  if (AW != $clog2(DEPTH) || TIMEOUT < 2) begin : g_bad_cfg
    $error("sse_sample_feeder: AW must equal clog2(DEPTH) and TIMEOUT must be >= 2");
  end

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic          stop_q, stop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   result_q, result_d;
  logic          sse_rst_q, sse_rst_d;
  logic          next_prev_q, next_prev_d;
  logic          ready_prev_q, ready_prev_d;

  logic [31:0]   buf_a_q [DEPTH];
  logic [31:0]   buf_a_d [DEPTH];
  logic [31:0]   buf_b_q [DEPTH];
  logic [31:0]   buf_b_d [DEPTH];

  logic          nxt_edge;
  logic          rdy_edge;
  logic [AW:0]   idx_nx;
  logic [AW-1:0] idx_inc;
  logic          start_ok;

`ifdef SSE_FEEDER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           error_q, error_d;
`endif

  assign nxt_edge = eng.next & ~next_prev_q;
  assign rdy_edge = eng.ready & ~ready_prev_q;
  assign idx_nx   = {1'b0, idx_q} + 1'b1;
  assign idx_inc  = idx_q + 1'b1;
  assign start_ok = start && (count != '0) && (count <= DEPTH_W);

  // Buffer write path: only accepted while idle so a run sees stable data.
  always_comb begin
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    if (wr_en && state_q == S_IDLE) begin
      if (wr_sel) buf_b_d[wr_addr] = wr_data;
      else        buf_a_d[wr_addr] = wr_data;
    end
  end

  // Run control: idle/start, pair streaming on next edges, drain to ready edge.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    stop_d       = stop_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    result_d     = result_q;
    sse_rst_d    = 1'b0;
    next_prev_d  = eng.next;
    ready_prev_d = eng.ready;
`ifdef SSE_FEEDER_TIMEOUT_EN
    wd_d         = wd_q;
    error_d      = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          cnt_d     = count;
          idx_d     = '0;
          a_d       = buf_a_q[0];
          b_d       = buf_b_q[0];
          sse_rst_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_STREAM;
`ifdef SSE_FEEDER_TIMEOUT_EN
          wd_d      = '0;
          error_d   = 1'b0;
`endif
        end
      end
      S_STREAM: begin
        if (nxt_edge) begin
          if (idx_nx < cnt_q) begin
            idx_d = idx_inc;
            a_d   = buf_a_q[idx_inc];
            b_d   = buf_b_q[idx_inc];
          end else begin
            a_d     = '0;
            b_d     = '0;
            stop_d  = 1'b1;
            state_d = S_DRAIN;
          end
`ifdef SSE_FEEDER_TIMEOUT_EN
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          stop_d  = 1'b0;
          a_d     = '0;
          b_d     = '0;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      S_DRAIN: begin
        if (rdy_edge) begin
          result_d = eng.Y;
          done_d   = 1'b1;
          stop_d   = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
`ifdef SSE_FEEDER_TIMEOUT_EN
        end else if (wd_q == WD_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          stop_d  = 1'b0;
          a_d     = '0;
          b_d     = '0;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer storage: contents deliberately survive reset.
  always_ff @(posedge clk) begin
    buf_a_q <= buf_a_d;
    buf_b_q <= buf_b_d;
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      sse_rst_q    <= 1'b0;
      next_prev_q  <= 1'b0;
      ready_prev_q <= 1'b0;
`ifdef SSE_FEEDER_TIMEOUT_EN
      wd_q         <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      stop_q       <= stop_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      sse_rst_q    <= sse_rst_d;
      next_prev_q  <= next_prev_d;
      ready_prev_q <= ready_prev_d;
`ifdef SSE_FEEDER_TIMEOUT_EN
      wd_q         <= wd_d;
      error_q      <= error_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign eng.A       = a_q;
  assign eng.B       = b_q;
  assign eng.stop    = stop_q;
  assign eng.sse_rst = sse_rst_q;
`ifdef SSE_FEEDER_TIMEOUT_EN
  assign error       = error_q;
`endif

endmodule

// File: tb/tb_sse_sample_feeder.sv
// Scoreboard bench for sse_sample_feeder: expected A/B pairs are queued when
// a run is started and popped as each pair appears on the engine side.
module tb_sse_sample_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   count;
  logic          start;
  logic          busy;
  logic          done;
  logic [31:0]   result;
`ifdef SSE_FEEDER_TIMEOUT_EN
  logic          error;
`endif

  sse_sample_feeder_if eng ();

  sse_sample_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(64)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .count   (count),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .result  (result),
`ifdef SSE_FEEDER_TIMEOUT_EN
    .error   (error),
`endif
    .eng     (eng)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] mdl_a [DEPTH];
  logic [31:0] mdl_b [DEPTH];
  logic [63:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_buf(input logic sel, input int unsigned addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    if (sel) mdl_b[addr] = data;
    else     mdl_a[addr] = data;
  endtask

  task automatic pop_ab(input string tag);
    logic [63:0] e;
    chk({tag, "_qsz"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_A"}, eng.A, e[63:32]);
      chk({tag, "_B"}, eng.B, e[31:0]);
    end
  endtask

  // Queue every pair of an n-pair run plus the zeroed pair shown in drain.
  task automatic do_start(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back({mdl_a[i], mdl_b[i]});
    exp_q.push_back(64'd0);
    count = (AW+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_sse_rst", 32'(eng.sse_rst), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    pop_ab("first_pair");
    tick();
    chk("sse_rst_one_cycle", 32'(eng.sse_rst), 32'd0);
  endtask

  task automatic adv(input logic last);
    eng.next = 1'b1;
    tick();
    eng.next = 1'b0;
    pop_ab("adv");
    chk("adv_stop", 32'(eng.stop), 32'(last));
    tick();
  endtask

  task automatic finish_run(input logic [31:0] y);
    eng.Y     = y;
    eng.ready = 1'b1;
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("result", result, y);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_stop", 32'(eng.stop), 32'd0);
    eng.ready = 1'b0;
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("result_hold", result, y);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    count = '0; start = 1'b0;
    eng.next = 1'b0; eng.ready = 1'b0; eng.Y = '0;
    for (int i = 0; i < DEPTH; i++) begin mdl_a[i] = '0; mdl_b[i] = '0; end
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_A", eng.A, 32'd0);
    chk("rst_B", eng.B, 32'd0);
    chk("rst_stop", 32'(eng.stop), 32'd0);
    chk("rst_sse_rst", 32'(eng.sse_rst), 32'd0);
    rst = 1'b1;
    tick();

    // Basic two-pair run: (3-1)^2 + (5-2)^2 = 13.0 returned by the engine.
    for (int i = 0; i < DEPTH; i++) begin wr_buf(1'b0, i, '0); wr_buf(1'b1, i, '0); end
    wr_buf(1'b0, 0, 32'h40400000);
    wr_buf(1'b0, 1, 32'h40A00000);
    wr_buf(1'b1, 0, 32'h3F800000);
    wr_buf(1'b1, 1, 32'h40000000);
    do_start(2);
    adv(1'b0);
    adv(1'b1);
    finish_run(32'h41500000);

    // Full-depth run: every entry in order, stop only after the last edge.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_buf(1'b0, i, 32'(i));
      wr_buf(1'b1, i, ~32'(i));
    end
    do_start(DEPTH);
    for (int unsigned i = 1; i < DEPTH; i++) adv(1'b0);
    adv(1'b1);
    finish_run(32'h12345678);

    // Out-of-range counts are ignored.
    count = '0; start = 1'b1; tick(); start = 1'b0;
    chk("cnt0_busy", 32'(busy), 32'd0);
    chk("cnt0_sse_rst", 32'(eng.sse_rst), 32'd0);
    chk("cnt0_A", eng.A, 32'd0);
    tick();
    count = 5'd17; start = 1'b1; tick(); start = 1'b0;
    chk("cnt17_busy", 32'(busy), 32'd0);
    chk("cnt17_sse_rst", 32'(eng.sse_rst), 32'd0);
    chk("cnt17_B", eng.B, 32'd0);
    tick();

    // Held next advances once; writes during the run are dropped;
    // ready already high on drain entry needs a fresh rising edge.
    do_start(3);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    eng.next = 1'b1;
    tick();
    pop_ab("hold_first");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_A", eng.A, mdl_a[1]);
      chk("hold_stop", 32'(eng.stop), 32'd0);
    end
    eng.next = 1'b0;
    tick();
    adv(1'b0);
    eng.ready = 1'b1;
    tick();
    adv(1'b1);
    chk("ready_high_no_done", 32'(done), 32'd0);
    chk("ready_high_stop", 32'(eng.stop), 32'd1);
    eng.ready = 1'b0;
    tick();
    chk("ready_low_no_done", 32'(done), 32'd0);
    finish_run(32'h0000BEEF);
    do_start(1);
    adv(1'b1);
    finish_run(32'h00000001);

    // Reset mid-stream aborts; the next run replays from index 0.
    do_start(4);
    adv(1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_stop", 32'(eng.stop), 32'd0);
    chk("abort_A", eng.A, 32'd0);
    chk("abort_B", eng.B, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    exp_q.delete();
    tick();
    do_start(2);
    adv(1'b0);
    adv(1'b1);
    finish_run(32'hCAFEF00D);

`ifdef SSE_FEEDER_TIMEOUT_EN
    // Watchdog: no next edges after start.
    count = 5'd2; start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i < 64; i++) tick();
    chk("wd_before_error", 32'(error), 32'd0);
    chk("wd_before_busy", 32'(busy), 32'd1);
    tick();
    chk("wd_error", 32'(error), 32'd1);
    chk("wd_busy", 32'(busy), 32'd0);
    chk("wd_done", 32'(done), 32'd0);
    tick();
    chk("wd_sticky", 32'(error), 32'd1);
    count = 5'd1; start = 1'b1; tick(); start = 1'b0;
    chk("wd_clear", 32'(error), 32'd0);
    chk("wd_restart_A", eng.A, mdl_a[0]);
    eng.next = 1'b1; tick(); eng.next = 1'b0; tick();
    finish_run(32'h00000007);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
